// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic PE: multiplier depth bounds,
// a stage-count clamp and a width/sign-aware saturating adder.
package systolic_pkg;

    localparam int MUL_STAGES_MIN = 1;
    localparam int MUL_STAGES_MAX = 4;
    localparam int ACC_MAX_W      = 128;

    function automatic int clamp_stages(input int n);
        if (n < MUL_STAGES_MIN) return MUL_STAGES_MIN;
        if (n > MUL_STAGES_MAX) return MUL_STAGES_MAX;
        return n;
    endfunction

    // Adds x+y as w-bit numbers (w <= ACC_MAX_W). With sat set, the result
    // clamps to the signed or unsigned w-bit range instead of wrapping.
    function automatic logic [ACC_MAX_W-1:0] sat_add(
        input logic [ACC_MAX_W-1:0] x,
        input logic [ACC_MAX_W-1:0] y,
        input int                   w,
        input bit                   sgn,
        input bit                   sat
    );
        logic [ACC_MAX_W:0]   s;
        logic [ACC_MAX_W-1:0] mask;
        logic [ACC_MAX_W-1:0] smax;
        logic [ACC_MAX_W-1:0] smin;
        logic [ACC_MAX_W-1:0] r;
        logic [6:0]           top;
        logic [7:0]           cpos;
        logic                 sx;
        logic                 sy;
        logic                 ss;
        logic                 cout;
        if (w >= ACC_MAX_W) mask = '1;
        else mask = (ACC_MAX_W'(1) << w) - ACC_MAX_W'(1);
        top  = 7'(w - 1);
        cpos = 8'(w);
        s    = {1'b0, x & mask} + {1'b0, y & mask};
        r    = s[ACC_MAX_W-1:0] & mask;
        cout = s[cpos];
        sx   = x[top];
        sy   = y[top];
        ss   = s[top];
        smax = mask >> 1;
        smin = smax + ACC_MAX_W'(1);
        if (sat) begin
            if (sgn) begin
                // Overflow only when both operands share a sign the sum lost.
                if (sx == sy && ss != sx) r = sx ? smin : smax;
            end else if (cout) begin
                r = mask;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_mul_pipe.sv
// Pipelined multiplier for the systolic PE: a*b extended to D_W_ACC, with
// valid/init/last carried alongside through MUL_STAGES registers.
// Ports: clk, rst, a, b, valid, init, last -> p, p_valid, p_init, p_last.
module pe_mul_pipe
    import systolic_pkg::*;
#(
    parameter int D_W        = 32,
    parameter int D_W_ACC    = 64,
    parameter int MUL_STAGES = 2,
    parameter int SIGNED     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_W-1:0]     a,
    input  logic [D_W-1:0]     b,
    input  logic               valid,
    input  logic               init,
    input  logic               last,
    output logic [D_W_ACC-1:0] p,
    output logic               p_valid,
    output logic               p_init,
    output logic               p_last
);

    localparam int NS = clamp_stages(MUL_STAGES);
    localparam int PW = 2 * D_W;

    logic signed [PW-1:0] prod_s;
    logic [PW-1:0]        prod_u;
    logic [D_W_ACC-1:0]   ext_s;
    logic [D_W_ACC-1:0]   ext_u;
    logic [D_W_ACC-1:0]   prod_x;

    assign prod_s = PW'($signed(a)) * PW'($signed(b));
    assign prod_u = PW'(a) * PW'(b);
    assign ext_u  = D_W_ACC'(prod_u);

    if (D_W_ACC > PW) begin : g_sext
        assign ext_s = {{(D_W_ACC - PW){prod_s[PW-1]}}, prod_s};
    end else begin : g_nosext
        assign ext_s = prod_s;
    end

    assign prod_x = (SIGNED != 0) ? ext_s : ext_u;

    logic [D_W_ACC-1:0] p_q [NS];
    logic [NS-1:0]      v_q;
    logic [NS-1:0]      i_q;
    logic [NS-1:0]      l_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NS; s++) p_q[s] <= '0;
            v_q <= '0;
            i_q <= '0;
            l_q <= '0;
        end else begin
            p_q[0] <= prod_x;
            v_q[0] <= valid;
            i_q[0] <= valid & init;
            l_q[0] <= valid & last;
            for (int s = 1; s < NS; s++) begin
                p_q[s] <= p_q[s-1];
                v_q[s] <= v_q[s-1];
                i_q[s] <= i_q[s-1];
                l_q[s] <= l_q[s-1];
            end
        end
    end

    assign p       = p_q[NS-1];
    assign p_valid = v_q[NS-1];
    assign p_init  = i_q[NS-1];
    assign p_last  = l_q[NS-1];

endmodule

// File: rtl/systolic_pe_mac.sv
// Systolic-array PE: forwards A east / B south, accumulates framed dot
// products and merges its results into a column drain chain.
// Ports: in_a/in_b/in_valid/in_init/in_last -> out_* (1-cycle forward);
// in_sum* upstream drain, out_sum* downstream drain; err_overflow sticky.
module systolic_pe_mac
    import systolic_pkg::*;
#(
    parameter int D_W        = 32,
    parameter int D_W_ACC    = 64,
    parameter int MUL_STAGES = 2,
    parameter int SIGNED     = 1,
    parameter int SATURATE   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_W-1:0]     in_a,
    input  logic [D_W-1:0]     in_b,
    input  logic               in_valid,
    input  logic               in_init,
    input  logic               in_last,
    output logic [D_W-1:0]     out_a,
    output logic [D_W-1:0]     out_b,
    output logic               out_valid,
    output logic               out_init,
    output logic               out_last,
    input  logic [D_W_ACC-1:0] in_sum,
    input  logic               in_sum_valid,
    output logic               in_sum_ready,
    output logic [D_W_ACC-1:0] out_sum,
    output logic               out_sum_valid,
    input  logic               out_sum_ready,
    output logic               err_overflow
);

    logic [D_W_ACC-1:0] p;
    logic               p_valid;
    logic               p_init;
    logic               p_last;

    pe_mul_pipe #(
        .D_W        (D_W),
        .D_W_ACC    (D_W_ACC),
        .MUL_STAGES (MUL_STAGES),
        .SIGNED     (SIGNED)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .a       (in_a),
        .b       (in_b),
        .valid   (in_valid),
        .init    (in_init),
        .last    (in_last),
        .p       (p),
        .p_valid (p_valid),
        .p_init  (p_init),
        .p_last  (p_last)
    );

    logic [D_W_ACC-1:0] acc;
    logic [D_W_ACC-1:0] base;
    logic [D_W_ACC-1:0] sum;
    logic [D_W_ACC-1:0] pend;
    logic               pend_valid;
    logic               out_free;
    logic               res_fire;
    logic               load_ok;

    // init restarts the sum, silently dropping any unfinished frame.
    assign base = p_init ? '0 : acc;
    assign sum  = D_W_ACC'(sat_add(ACC_MAX_W'(base), ACC_MAX_W'(p),
                                   D_W_ACC, SIGNED != 0, SATURATE != 0));

    assign out_free = !out_sum_valid || out_sum_ready;
    assign res_fire = p_valid && p_last;
    // A full slot may still take a result in the cycle it drains.
    assign load_ok  = !pend_valid || out_free;

    assign in_sum_ready = !rst && out_free && !pend_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_a         <= '0;
            out_b         <= '0;
            out_valid     <= 1'b0;
            out_init      <= 1'b0;
            out_last      <= 1'b0;
            acc           <= '0;
            pend          <= '0;
            pend_valid    <= 1'b0;
            out_sum       <= '0;
            out_sum_valid <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            out_a     <= in_a;
            out_b     <= in_b;
            out_valid <= in_valid;
            out_init  <= in_init;
            out_last  <= in_last;

            if (p_valid) acc <= sum;

            if (res_fire && load_ok) begin
                pend       <= sum;
                pend_valid <= 1'b1;
            end else if (pend_valid && out_free) begin
                pend_valid <= 1'b0;
            end

            if (res_fire && !load_ok) err_overflow <= 1'b1;

            // Local results take priority over upstream pass-through.
            if (out_free) begin
                if (pend_valid) begin
                    out_sum       <= pend;
                    out_sum_valid <= 1'b1;
                end else if (in_sum_valid) begin
                    out_sum       <= in_sum;
                    out_sum_valid <= 1'b1;
                end else begin
                    out_sum_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_pe_mac.sv
// Directed bench for systolic_pe_mac: four instances cover signed/wrap,
// saturate, 16-bit wrap and unsigned configurations.
module tb_systolic_pe_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic        rst;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_valid;
    logic        in_init;
    logic        in_last;
    logic [31:0] in_sum;
    logic        in_sum_valid;
    logic        out_sum_ready;
    logic        aux_ready;

    logic [7:0]  out_a, out_b;
    logic        out_valid, out_init, out_last;
    logic        in_sum_ready;
    logic [31:0] out_sum;
    logic        out_sum_valid, err_overflow;

    logic [7:0]  sat_a, sat_b;
    logic        sat_v, sat_i, sat_l, sat_rdy, sat_sv, sat_err;
    logic [15:0] sat_sum;

    logic [7:0]  wrap_a, wrap_b;
    logic        wrap_v, wrap_i, wrap_l, wrap_rdy, wrap_sv, wrap_err;
    logic [15:0] wrap_sum;

    logic [7:0]  uns_a, uns_b;
    logic        uns_v, uns_i, uns_l, uns_rdy, uns_sv, uns_err;
    logic [31:0] uns_sum;

    systolic_pe_mac #(.D_W(8), .D_W_ACC(32), .MUL_STAGES(2),
                      .SIGNED(1), .SATURATE(0)) u_dut (
        .clk(clk), .rst(rst),
        .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
        .in_init(in_init), .in_last(in_last),
        .out_a(out_a), .out_b(out_b), .out_valid(out_valid),
        .out_init(out_init), .out_last(out_last),
        .in_sum(in_sum), .in_sum_valid(in_sum_valid),
        .in_sum_ready(in_sum_ready),
        .out_sum(out_sum), .out_sum_valid(out_sum_valid),
        .out_sum_ready(out_sum_ready), .err_overflow(err_overflow)
    );

    systolic_pe_mac #(.D_W(8), .D_W_ACC(16), .MUL_STAGES(2),
                      .SIGNED(1), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst),
        .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
        .in_init(in_init), .in_last(in_last),
        .out_a(sat_a), .out_b(sat_b), .out_valid(sat_v),
        .out_init(sat_i), .out_last(sat_l),
        .in_sum(16'h0), .in_sum_valid(1'b0), .in_sum_ready(sat_rdy),
        .out_sum(sat_sum), .out_sum_valid(sat_sv),
        .out_sum_ready(aux_ready), .err_overflow(sat_err)
    );

    systolic_pe_mac #(.D_W(8), .D_W_ACC(16), .MUL_STAGES(2),
                      .SIGNED(1), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst),
        .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
        .in_init(in_init), .in_last(in_last),
        .out_a(wrap_a), .out_b(wrap_b), .out_valid(wrap_v),
        .out_init(wrap_i), .out_last(wrap_l),
        .in_sum(16'h0), .in_sum_valid(1'b0), .in_sum_ready(wrap_rdy),
        .out_sum(wrap_sum), .out_sum_valid(wrap_sv),
        .out_sum_ready(aux_ready), .err_overflow(wrap_err)
    );

    systolic_pe_mac #(.D_W(8), .D_W_ACC(32), .MUL_STAGES(2),
                      .SIGNED(0), .SATURATE(0)) u_uns (
        .clk(clk), .rst(rst),
        .in_a(in_a), .in_b(in_b), .in_valid(in_valid),
        .in_init(in_init), .in_last(in_last),
        .out_a(uns_a), .out_b(uns_b), .out_valid(uns_v),
        .out_init(uns_i), .out_last(uns_l),
        .in_sum(32'h0), .in_sum_valid(1'b0), .in_sum_ready(uns_rdy),
        .out_sum(uns_sum), .out_sum_valid(uns_sv),
        .out_sum_ready(aux_ready), .err_overflow(uns_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b,
                        input logic i, input logic l);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        in_init  = i;
        in_last  = l;
        tick();
        in_a     = '0;
        in_b     = '0;
        in_valid = 1'b0;
        in_init  = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [58:0] obs;
        tick();
        tick();
        obs = {out_a, out_b, out_valid, out_init, out_last, in_sum_ready,
               out_sum, out_sum_valid, err_overflow};
        total++;
        if (obs !== '0) $display("FAIL reset_outputs got %h want 0", obs);
        else passed++;
        total++;
        if ({sat_sum, sat_sv, sat_err, uns_sum, uns_sv} !== '0)
            $display("FAIL reset_aux got sat=%h uns=%h want 0",
                     sat_sum, uns_sum);
        else passed++;
        rst = 1'b0;
        tick();
        total++;
        if (in_sum_ready !== 1'b1 || out_sum_valid !== 1'b0)
            $display("FAIL reset_release got rdy=%b v=%b want rdy=1 v=0",
                     in_sum_ready, out_sum_valid);
        else passed++;
    endtask

    task automatic test_dot_product();
        out_sum_ready = 1'b1;
        beat(8'd3, 8'd4, 1'b1, 1'b0);
        beat(8'hFE, 8'd5, 1'b0, 1'b0);
        beat(8'd7, 8'd7, 1'b0, 1'b1);
        tick();
        tick();
        total++;
        if (in_sum_ready !== 1'b0 || out_sum_valid !== 1'b0)
            $display("FAIL dot_pending got rdy=%b v=%b want rdy=0 v=0",
                     in_sum_ready, out_sum_valid);
        else passed++;
        tick();
        total++;
        if (out_sum !== 32'(12 - 10 + 49) || out_sum_valid !== 1'b1)
            $display("FAIL dot_result got %0d v=%b want 51 v=1",
                     $signed(out_sum), out_sum_valid);
        else passed++;
        tick();
        total++;
        if (out_sum_valid !== 1'b0)
            $display("FAIL dot_once got v=%b want 0", out_sum_valid);
        else passed++;
    endtask

    task automatic test_saturate();
        do_reset();
        beat(8'd127, 8'd127, 1'b1, 1'b0);
        beat(8'd127, 8'd127, 1'b0, 1'b0);
        beat(8'd127, 8'd127, 1'b0, 1'b0);
        beat(8'd127, 8'd127, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        total++;
        if (sat_sum !== 16'h7FFF || sat_sv !== 1'b1)
            $display("FAIL sat_clamp got %h v=%b want 7fff v=1",
                     sat_sum, sat_sv);
        else passed++;
        total++;
        if (wrap_sum !== 16'hFC04 || wrap_sv !== 1'b1)
            $display("FAIL wrap_result got %h v=%b want fc04 v=1",
                     wrap_sum, wrap_sv);
        else passed++;
    endtask

    task automatic test_unsigned();
        do_reset();
        beat(8'hFF, 8'hFF, 1'b1, 1'b1);
        total++;
        if ({uns_a, uns_b, uns_v, uns_i, uns_l} !== {16'hFFFF, 3'b111})
            $display("FAIL fwd_next got a=%h b=%h v=%b want ff ff 1",
                     uns_a, uns_b, uns_v);
        else passed++;
        tick();
        total++;
        if (uns_v !== 1'b0 || uns_a !== 8'h00)
            $display("FAIL fwd_onecycle got a=%h v=%b want 00 0",
                     uns_a, uns_v);
        else passed++;
        tick();
        tick();
        total++;
        if (uns_sum !== 32'd65025 || uns_sv !== 1'b1)
            $display("FAIL uns_result got %0d v=%b want 65025 v=1",
                     uns_sum, uns_sv);
        else passed++;
        total++;
        if (out_sum !== 32'd1 || out_sum_valid !== 1'b1)
            $display("FAIL signed_m1 got %0d v=%b want 1 v=1",
                     out_sum, out_sum_valid);
        else passed++;
    endtask

    task automatic test_drain_order();
        do_reset();
        out_sum_ready = 1'b0;
        beat(8'd5, 8'd6, 1'b1, 1'b1);
        tick();
        tick();
        in_sum       = 32'hAA;
        in_sum_valid = 1'b1;
        #1;
        total++;
        if (in_sum_ready !== 1'b0)
            $display("FAIL drain_pend_rdy got %b want 0", in_sum_ready);
        else passed++;
        tick();
        for (int k = 0; k < 10; k++) begin
            total++;
            if (out_sum !== 32'd30 || out_sum_valid !== 1'b1 ||
                in_sum_ready !== 1'b0)
                $display("FAIL drain_hold%0d got %h v=%b r=%b want 1e 1 0",
                         k, out_sum, out_sum_valid, in_sum_ready);
            else passed++;
            tick();
        end
        out_sum_ready = 1'b1;
        #1;
        total++;
        if (in_sum_ready !== 1'b1)
            $display("FAIL drain_open got %b want 1", in_sum_ready);
        else passed++;
        tick();
        in_sum_valid = 1'b0;
        total++;
        if (out_sum !== 32'hAA || out_sum_valid !== 1'b1)
            $display("FAIL drain_up got %h v=%b want aa v=1",
                     out_sum, out_sum_valid);
        else passed++;
        tick();
        total++;
        if (out_sum_valid !== 1'b0)
            $display("FAIL drain_empty got v=%b want 0", out_sum_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_sum_ready = 1'b0;
        beat(8'd1, 8'd2, 1'b1, 1'b1);
        beat(8'd3, 8'd4, 1'b1, 1'b1);
        beat(8'd5, 8'd6, 1'b1, 1'b1);
        tick();
        total++;
        if (out_sum !== 32'd2 || in_sum_ready !== 1'b0 ||
            err_overflow !== 1'b0)
            $display("FAIL b2b_first got %0d r=%b e=%b want 2 0 0",
                     out_sum, in_sum_ready, err_overflow);
        else passed++;
        tick();
        total++;
        if (err_overflow !== 1'b1 || out_sum !== 32'd2)
            $display("FAIL b2b_drop got e=%b s=%0d want e=1 s=2",
                     err_overflow, out_sum);
        else passed++;
        out_sum_ready = 1'b1;
        tick();
        total++;
        if (out_sum !== 32'd12 || out_sum_valid !== 1'b1)
            $display("FAIL b2b_second got %0d v=%b want 12 v=1",
                     out_sum, out_sum_valid);
        else passed++;
        tick();
        total++;
        if (out_sum_valid !== 1'b0 || err_overflow !== 1'b1)
            $display("FAIL b2b_third got v=%b e=%b want v=0 e=1",
                     out_sum_valid, err_overflow);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        logic [58:0] obs;
        do_reset();
        out_sum_ready = 1'b1;
        beat(8'd3, 8'd4, 1'b1, 1'b0);
        beat(8'd5, 8'd5, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        obs = {out_a, out_b, out_valid, out_init, out_last, in_sum_ready,
               out_sum, out_sum_valid, err_overflow};
        total++;
        if (obs !== '0) $display("FAIL mid_reset got %h want 0", obs);
        else passed++;
        rst = 1'b0;
        tick();
        beat(8'd2, 8'd3, 1'b0, 1'b0);
        beat(8'd1, 8'd1, 1'b0, 1'b1);
        tick();
        tick();
        total++;
        if (out_sum_valid !== 1'b0)
            $display("FAIL mid_stale got v=%b want 0", out_sum_valid);
        else passed++;
        tick();
        total++;
        if (out_sum !== 32'd7 || out_sum_valid !== 1'b1)
            $display("FAIL mid_fresh got %0d v=%b want 7 v=1",
                     out_sum, out_sum_valid);
        else passed++;
    endtask

    initial begin
        rst           = 1'b1;
        in_a          = '0;
        in_b          = '0;
        in_valid      = 1'b0;
        in_init       = 1'b0;
        in_last       = 1'b0;
        in_sum        = '0;
        in_sum_valid  = 1'b0;
        out_sum_ready = 1'b1;
        aux_ready     = 1'b1;
        test_reset();
        test_dot_product();
        test_saturate();
        test_unsigned();
        test_drain_order();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
